// File: rtl/data_ram.sv
// -----------------------------------------------------------------------------
// data_ram - byte-addressed data memory for the load/store stage.
//
// Supports byte, half and word accesses. Loads can be sign- or zero-extended.
// Accesses that are not naturally aligned are rejected. After every reset, a
// hardware sequence zeroes the whole array before any request is accepted.
//
// Ports:
//   clk            rising-edge clock
//   rst            synchronous, active-high reset
//   req_in         request strobe (one access per asserted cycle)
//   write_enable   1 = store, 0 = load (sampled only with req_in)
//   size_in        00 byte, 01 half, 10 word, 11 reserved (always rejected)
//   unsigned_in    loads: 1 = zero-extend, 0 = sign-extend
//   addr_in        byte address; word index = addr_in[ADDR_WIDTH-1:2]
//   data_in        store data, right-aligned
//   data_out       registered load result
//   valid_out      one-cycle pulse: previous-cycle request completed
//   misaligned_out qualifies valid_out: completed request was rejected
//   busy_out       clear sequence running; requests are ignored
// -----------------------------------------------------------------------------
module data_ram #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_in,
    input  logic                  write_enable,
    input  logic [1:0]            size_in,
    input  logic                  unsigned_in,
    input  logic [ADDR_WIDTH-1:0] addr_in,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  valid_out,
    output logic                  misaligned_out,
    output logic                  busy_out
);

    localparam int IDX_W = ADDR_WIDTH - 2;
    localparam int DEPTH = 2 ** IDX_W;

    // The lane steering below assumes four 8-bit lanes per word.
    generate
        if (DATA_WIDTH != 32) begin : g_width_check
            $error("data_ram: DATA_WIDTH must be 32");
        end
    endgenerate

    typedef enum logic {
        S_CLEAR,
        S_IDLE
    } state_t;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } size_t;

    state_t                  state_q, state_d;
    logic [IDX_W-1:0]        clr_cnt_q, clr_cnt_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic                    valid_q, valid_d;
    logic                    mis_q, mis_d;

    logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

    logic [IDX_W-1:0]        word_idx;
    logic [1:0]              lane;
    logic                    misaligned;
    logic                    do_store;
    logic [3:0]              byte_en;
    logic [DATA_WIDTH-1:0]   wr_data;
    logic [DATA_WIDTH-1:0]   rd_word;
    logic [7:0]              byte_val;
    logic [15:0]             half_val;
    logic [DATA_WIDTH-1:0]   load_result;

    // -------------------------------------------------------------------------
    // Request decode: alignment, lane enables, store replication, load extract
    // -------------------------------------------------------------------------
    // NOTE: every signal driven here gets a default first, so no path through
    // the case statements can leave a value unassigned and infer a latch.
    always_comb begin
        word_idx    = addr_in[ADDR_WIDTH-1:2];
        lane        = addr_in[1:0];
        misaligned  = 1'b0;
        byte_en     = 4'b0000;
        wr_data     = data_in;
        load_result = '0;

        rd_word  = mem_q[word_idx];
        byte_val = rd_word[{lane, 3'b000} +: 8];
        half_val = rd_word[{lane[1], 4'b0000} +: 16];

        case (size_in)
            SZ_BYTE: begin
                byte_en     = 4'b0001 << lane;
                wr_data     = {4{data_in[7:0]}};
                load_result = {{24{byte_val[7] & ~unsigned_in}}, byte_val};
            end
            SZ_HALF: begin
                misaligned  = lane[0];
                byte_en     = lane[1] ? 4'b1100 : 4'b0011;
                wr_data     = {2{data_in[15:0]}};
                load_result = {{16{half_val[15] & ~unsigned_in}}, half_val};
            end
            SZ_WORD: begin
                misaligned  = (lane != 2'b00);
                byte_en     = 4'b1111;
                load_result = rd_word;
            end
            default: misaligned = 1'b1;
        endcase

        // A store coinciding with reset is dropped along with its response.
        do_store = (state_q == S_IDLE) && req_in && write_enable && !misaligned && !rst;
    end

    // -------------------------------------------------------------------------
    // Control FSM and output next-state
    // -------------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        data_d    = data_q;
        valid_d   = 1'b0;
        mis_d     = 1'b0;

        case (state_q)
            S_CLEAR: begin
                clr_cnt_d = clr_cnt_q + 1'b1;
                if (clr_cnt_q == IDX_W'(DEPTH - 1)) begin
                    state_d = S_IDLE;
                end
            end
            S_IDLE: begin
                if (req_in) begin
                    valid_d = 1'b1;
                    if (misaligned) begin
                        mis_d  = 1'b1;
                        data_d = '0;
                    end else if (!write_enable) begin
                        data_d = load_result;
                    end
                end
            end
            default: state_d = S_CLEAR;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // values from before the edge, independent of process ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_CLEAR;
            clr_cnt_q <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            mis_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            mis_q     <= mis_d;
        end
    end

    // -------------------------------------------------------------------------
    // Storage: one write port shared by the clear sequence and stores
    // -------------------------------------------------------------------------
    // NOTE: the array has no reset branch; a reset on every word would turn it
    // into flops. Zeroing is done one word per cycle by the CLEAR state.
    always_ff @(posedge clk) begin
        if (state_q == S_CLEAR) begin
            mem_q[clr_cnt_q] <= '0;
        end else if (do_store) begin
            for (int i = 0; i < 4; i++) begin
                if (byte_en[i]) begin
                    mem_q[word_idx][i*8 +: 8] <= wr_data[i*8 +: 8];
                end
            end
        end
    end

    assign data_out       = data_q;
    assign valid_out      = valid_q;
    assign misaligned_out = mis_q;
    assign busy_out       = (state_q == S_CLEAR);

endmodule

// File: tb/tb_data_ram.sv
// -----------------------------------------------------------------------------
// tb_data_ram - scoreboard bench for data_ram.
//
// A byte-array model predicts each response when the request is issued and
// queues it; a monitor on the falling edge pops and compares whenever the DUT
// raises valid_out. Directed cases cover clear timing, lanes, extension,
// misalignment, reset mid-operation and idle hold, followed by random traffic.
// -----------------------------------------------------------------------------
module tb_data_ram;

    localparam int DEPTH = 256;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_in;
    logic        write_enable;
    logic [1:0]  size_in;
    logic        unsigned_in;
    logic [9:0]  addr_in;
    logic [31:0] data_in;
    logic [31:0] data_out;
    logic        valid_out;
    logic        misaligned_out;
    logic        busy_out;

    data_ram #(.DATA_WIDTH(32), .ADDR_WIDTH(10)) dut (
        .clk            (clk),
        .rst            (rst),
        .req_in         (req_in),
        .write_enable   (write_enable),
        .size_in        (size_in),
        .unsigned_in    (unsigned_in),
        .addr_in        (addr_in),
        .data_in        (data_in),
        .data_out       (data_out),
        .valid_out      (valid_out),
        .misaligned_out (misaligned_out),
        .busy_out       (busy_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic        mis;
    } exp_t;

    exp_t        sb_q[$];
    logic [7:0]  mem_m [0:1023];
    logic [31:0] last_data;
    int          vectors    = 0;
    int          miscompares = 0;
    bit          mon_en     = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int nbytes(input logic [1:0] sz);
        return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    endfunction

    function automatic bit aligned(input logic [1:0] sz, input logic [9:0] addr);
        case (sz)
            2'b00:   return 1'b1;
            2'b01:   return addr % 2 == 0;
            2'b10:   return addr % 4 == 0;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] model_load(input logic [1:0] sz, input bit uns,
                                               input logic [9:0] addr);
        logic [31:0] v = 32'h0;
        int n = nbytes(sz);
        for (int i = 0; i < n; i++) v = v | (32'(mem_m[int'(addr) + i]) << (8 * i));
        if (!uns && n == 1 && v[7])  v = v | 32'hFFFF_FF00;
        if (!uns && n == 2 && v[15]) v = v | 32'hFFFF_0000;
        return v;
    endfunction

    // Issues one request, predicts its response, advances one cycle.
    task automatic issue(input bit we, input logic [1:0] sz, input bit uns,
                         input logic [9:0] addr, input logic [31:0] wd);
        exp_t e;
        if (!aligned(sz, addr)) begin
            e.data = 32'h0;
            e.mis  = 1'b1;
        end else if (we) begin
            for (int i = 0; i < nbytes(sz); i++) mem_m[int'(addr) + i] = wd[8*i +: 8];
            e.data = last_data;
            e.mis  = 1'b0;
        end else begin
            e.data = model_load(sz, uns, addr);
            e.mis  = 1'b0;
        end
        last_data = e.data;
        sb_q.push_back(e);
        req_in       = 1'b1;
        write_enable = we;
        size_in      = sz;
        unsigned_in  = uns;
        addr_in      = addr;
        data_in      = wd;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycle();
        req_in = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // Applies a one-cycle reset with a word load to `addr` held on the bus,
    // then measures the clear sequence length.
    task automatic reset_and_clear(input logic [9:0] addr);
        int cycles;
        rst          = 1'b1;
        req_in       = 1'b1;
        write_enable = 1'b0;
        size_in      = 2'b10;
        unsigned_in  = 1'b0;
        addr_in      = addr;
        data_in      = 32'h0;
        @(posedge clk);
        #1;
        mon_en = 1'b1;
        check("rst_data_out", data_out, 32'h0);
        check("rst_valid_out", 32'(valid_out), 32'h0);
        check("rst_misaligned_out", 32'(misaligned_out), 32'h0);
        check("rst_busy_out", 32'(busy_out), 32'h1);
        for (int i = 0; i < 1024; i++) mem_m[i] = 8'h00;
        last_data = 32'h0;
        rst = 1'b0;
        cycles = 0;
        while (busy_out === 1'b1 && cycles < 2 * DEPTH + 8) begin
            cycles++;
            @(posedge clk);
            #1;
        end
        check("busy_cycles", 32'(cycles), 32'(DEPTH));
        req_in = 1'b0;
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (mon_en) begin
            if (valid_out === 1'b1) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_valid", 32'h1, 32'h0);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check("resp_data", data_out, e.data);
                    check("resp_misaligned", 32'(misaligned_out), 32'(e.mis));
                end
            end else begin
                check("valid_known", 32'(valid_out), 32'h0);
                check("mis_without_valid", 32'(misaligned_out), 32'h0);
            end
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    initial begin
        rst          = 1'b1;
        req_in       = 1'b0;
        write_enable = 1'b0;
        size_in      = 2'b00;
        unsigned_in  = 1'b0;
        addr_in      = '0;
        data_in      = '0;
        last_data    = 32'h0;
        @(negedge clk);

        // Reset clear with a request held during the whole sequence.
        reset_and_clear(10'h01C);
        issue(1'b0, 2'b10, 1'b0, 10'h01C, 32'h0);

        // Word store/load, back to back.
        issue(1'b1, 2'b10, 1'b0, 10'h01C, 32'h0000_0004);
        issue(1'b1, 2'b10, 1'b0, 10'h06C, 32'h0000_0005);
        issue(1'b0, 2'b10, 1'b0, 10'h01C, 32'h0);
        issue(1'b0, 2'b10, 1'b0, 10'h06C, 32'h0);

        // Byte lanes and extension.
        issue(1'b1, 2'b00, 1'b0, 10'h01D, 32'h0000_0080);
        issue(1'b0, 2'b00, 1'b0, 10'h01D, 32'h0);
        issue(1'b0, 2'b00, 1'b1, 10'h01D, 32'h0);
        issue(1'b0, 2'b10, 1'b0, 10'h01C, 32'h0);
        issue(1'b0, 2'b01, 1'b0, 10'h01C, 32'h0);

        // Misalignment.
        issue(1'b1, 2'b01, 1'b0, 10'h01B, 32'h0000_BEEF);
        issue(1'b0, 2'b10, 1'b0, 10'h018, 32'h0);
        issue(1'b0, 2'b11, 1'b0, 10'h020, 32'h0);

        // Idle hold after a load returning 7.
        issue(1'b1, 2'b10, 1'b0, 10'h030, 32'h0000_0007);
        issue(1'b0, 2'b10, 1'b0, 10'h030, 32'h0);
        for (int k = 0; k < 5; k++) begin
            idle_cycle();
            check("idle_valid", 32'(valid_out), 32'h0);
            check("idle_data_hold", data_out, 32'h0000_0007);
        end

        // Random traffic, concentrated on a small window for read-after-write.
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 4) == 0) begin
                idle_cycle();
            end else begin
                logic [9:0] a;
                a = ($urandom_range(0, 7) == 0) ? 10'($urandom_range(0, 1023))
                                                : 10'($urandom_range(0, 63));
                issue(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                      1'($urandom_range(0, 1)), a, $urandom);
            end
        end

        // Reset mid-operation with a load in flight.
        issue(1'b1, 2'b10, 1'b0, 10'h040, 32'h0000_1234);
        reset_and_clear(10'h040);
        issue(1'b0, 2'b10, 1'b0, 10'h040, 32'h0);

        req_in = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        check("scoreboard_drained", 32'(sb_q.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
